// File: rtl/spi_cmd_sequencer.sv
// Byte-oriented command sequencer between an SPI byte FIFO pair and a small
// register file: fetch command (and data for writes), execute, send one response byte.
module spi_cmd_sequencer #(
  parameter logic [7:0] RESP_ACK = 8'hA5,
  parameter logic [7:0] RESP_ERR = 8'hEE
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       rd_empty,
  input  logic       rd_ack,
  input  logic [7:0] rd_buffer,
  output logic       read,
  input  logic       wr_full,
  input  logic       wr_ack,
  output logic [7:0] wr_buffer,
  output logic       write,
  output logic [2:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {S_FETCH_CMD, S_FETCH_DATA, S_EXEC, S_SEND} state_t;

  state_t state;
  logic   started;   // holds off the first read request until one edge after reset release
  logic   cmd_wr;

  logic rd_take, wr_take, malformed;
  assign rd_take   = read && rd_ack;
  assign wr_take   = write && wr_ack;
  assign malformed = (rd_buffer[6:3] != 4'b0000);
  assign busy      = (state != S_FETCH_CMD);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= S_FETCH_CMD;
      started   <= 1'b0;
      cmd_wr    <= 1'b0;
      read      <= 1'b0;
      write     <= 1'b0;
      wr_buffer <= 8'h00;
      reg_addr  <= 3'd0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      err_count <= 8'h00;
    end else begin
      started <= 1'b1;
      reg_we  <= 1'b0;
      case (state)
        S_FETCH_CMD: begin
          if (rd_take) begin
            read     <= 1'b0;
            reg_addr <= rd_buffer[2:0];
            cmd_wr   <= rd_buffer[7];
            if (malformed) begin
              wr_buffer <= RESP_ERR;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state <= S_SEND;
            end else if (rd_buffer[7]) begin
              state <= S_FETCH_DATA;
            end else begin
              state <= S_EXEC;
            end
          end else if (!read && !rd_empty && started) begin
            read <= 1'b1;
          end
        end
        S_FETCH_DATA: begin
          if (rd_take) begin
            read      <= 1'b0;
            reg_wdata <= rd_buffer;
            // Only write commands reach this state, so the strobe lands exactly in EXEC.
            reg_we    <= 1'b1;
            state     <= S_EXEC;
          end else if (!read && !rd_empty) begin
            read <= 1'b1;
          end
        end
        S_EXEC: begin
          wr_buffer <= cmd_wr ? RESP_ACK : reg_rdata;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (wr_take) begin
            write <= 1'b0;
            state <= S_FETCH_CMD;
          end else if (!write && !wr_full) begin
            write <= 1'b1;
          end
        end
        default: state <= S_FETCH_CMD;
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter: RESP_ACK, default 8'hA5, response byte returned after a completed register write.
REQ-002 Parameter: RESP_ERR, default 8'hEE, response byte returned after a malformed command.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_L  input  1  reset, asynchronous and active-low.
REQ-005 Port: rd_empty  input  1  SPI receive buffer holds no byte.
REQ-006 Port: rd_ack  input  1  receive side accepted the read request; rd_buffer valid this cycle.
REQ-007 Port: rd_buffer  input  8  received byte.
REQ-008 Port: read  output  1  read request to the receive side.
REQ-009 Port: wr_full  input  1  SPI transmit buffer cannot accept a byte.
REQ-010 Port: wr_ack  input  1  transmit side accepted wr_buffer this cycle.
REQ-011 Port: wr_buffer  output  8  byte to transmit.
REQ-012 Port: write  output  1  write request to the transmit side.
REQ-013 Port: reg_addr  output  3  register-file address.
REQ-014 Port: reg_wdata  output  8  register-file write data.
REQ-015 Port: reg_we  output  1  register-file write strobe, one cycle.
REQ-016 Port: reg_rdata  input  8  register-file read data, combinational from reg_addr.
REQ-017 Port: busy  output  1  high in any state other than FETCH_CMD.
REQ-018 Port: err_count  output  8  count of malformed commands, saturating at 8'hFF.

Function
REQ-019 Command byte format: bit7 = 1 write / 0 read; bits[6:3] shall be 4'b0000, otherwise the command is malformed; bits[2:0] = register address.
REQ-020 States: FETCH_CMD, FETCH_DATA, EXEC, SEND; one-hot or binary encoding is free.
REQ-021 Read handshake: in FETCH_CMD/FETCH_DATA, when ~read and ~rd_empty, set read next cycle; hold read until the cycle rd_ack=1; capture rd_buffer in that cycle; clear read on the following edge.
REQ-022 FETCH_CMD on capture: load reg_addr <= bits[2:0]; malformed -> wr_buffer <= RESP_ERR, err_count += 1 (saturating), go to SEND; valid write -> FETCH_DATA; valid read -> EXEC.
REQ-023 FETCH_DATA on capture: reg_wdata <= rd_buffer, go to EXEC.
REQ-024 EXEC lasts exactly one cycle: write command -> reg_we=1 this cycle, wr_buffer <= RESP_ACK; read command -> wr_buffer <= reg_rdata; then go to SEND.
REQ-025 Write handshake: in SEND, when ~write and ~wr_full, set write next cycle; hold write and wr_buffer stable until the cycle wr_ack=1; clear write on the following edge and return to FETCH_CMD.
REQ-026 read and write shall never be high in the same cycle; read shall never be set while in EXEC or SEND.
REQ-027 rd_ack while read=0 and wr_ack while write=0 shall be ignored.
REQ-028 wr_full rising while write is already high shall not drop write; the request is held until wr_ack.
REQ-029 rd_empty rising while read is already high shall not drop read; the request is held until rd_ack.
REQ-030 reg_we shall be high only in EXEC of a valid write command, never otherwise.
REQ-031 Minimum command-to-response latency with zero-wait acks: read command 4 cycles from read assertion to write assertion; write command 6 cycles.

Reset
REQ-032 On rst_L=0, asynchronously: state=FETCH_CMD, read=0, write=0, wr_buffer=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, err_count=0.
REQ-033 Reset mid-transaction shall abandon the command; no reg_we pulse and no response shall be issued after release.
REQ-034 First read request shall assert no earlier than the second rising edge after rst_L deasserts.

Verification
REQ-035 Write then read: bytes 8'h83, 8'h5C, then 8'h03 -> reg_we pulse with addr 3, data 8'h5C; responses 8'hA5 then 8'h5C.
REQ-036 Malformed: byte 8'h48 -> no reg_we; response 8'hEE; err_count 0->1; sequencer returns to FETCH_CMD.
REQ-037 Backpressure: wr_full=1 for 10 cycles during SEND -> write stays 0, then asserts once wr_full=0; response byte unchanged.
REQ-038 Slow acks: rd_ack delayed 5 cycles, wr_ack delayed 3 cycles -> read/write held high throughout, each deasserts exactly one cycle after its ack.
REQ-039 Saturation and reset: 256 malformed bytes -> err_count=8'hFF; assert rst_L=0 during FETCH_DATA -> all outputs at reset values immediately, no reg_we.
